deserialize: RTL and testbench
==============================

Name: deserialize

Overview:
- Downstream companion of the argument serializer.
- Consumes a stream of tagged words {index, data}, where index is the argument slot, and reassembles them into one parallel ARGN-wide frame.
- Emits the frame on a strobe/ready result port once every slot has been filled.
- Sits between the shared serial link and the parallel-argument compute units.

Parameters:
- ARGW, 16, width of one argument word.
- ARGN, 2, number of argument slots per frame (>= 2); IDXW = $clog2(ARGN).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- arg_stb  input  1  tagged word valid.
- arg_dat  input  IDXW+ARGW  tagged word: [IDXW+ARGW-1:ARGW] = slot index, [ARGW-1:0] = data.
- arg_rdy  output  1  word accepted when arg_stb & arg_rdy at a rising edge.
- res_stb  output  1  assembled frame valid (registered).
- res_dat  output  ARGN*ARGW  frame; slot n occupies res_dat[ARGW*n +: ARGW] (registered).
- res_rdy  input  1  frame consumed when res_stb & res_rdy at a rising edge.

Behaviour:
- Reset: single clock clk; synchronous active-high rst. On rst, res_stb=0, res_dat=0, fill mask=0, staging buffer contents don't-care. Reset mid-frame discards the partial frame and any held output frame. Power-up initial values equal the reset values.
- State:
  - Staging buffer buf[ARGN] and fill mask msk[ARGN] (collection side).
  - Output register res_dat/res_stb (delivery side).
  - The two sides operate concurrently, giving 2-frame buffering.
- Definitions: idx = arg_dat index field; dat = data field; full = &msk; out_free = ~res_stb | res_rdy.
- arg_rdy (combinational, independent of arg_stb):
  - If full: 0.
  - Else if idx >= ARGN: 1 (out-of-range tag; word is accepted and discarded, no state change).
  - Else: ~msk[idx]. A duplicate tag stalls until the current frame has been transferred out; it never overwrites.
- Accept (arg_stb & arg_rdy, idx < ARGN): buf[idx] <= dat, msk[idx] <= 1. Word arrival order is arbitrary.
- Transfer (full & out_free):
  - res_dat <= buf packed by slot, res_stb <= 1, msk <= 0.
  - No word can be accepted in a transfer cycle, since arg_rdy=0 while full.
- Delivery: if res_ack (res_stb & res_rdy) and no transfer that cycle, res_stb <= 0. Transfer and res_ack in the same cycle keep res_stb=1 with the new frame (back-to-back, no bubble).
- res_dat and res_stb hold stable while res_stb & ~res_rdy.
- Latency: last word accepted at edge N -> msk full after N; res_stb=1 after edge N+1 (if out_free).
- Throughput: max one frame per ARGN+1 cycles; collection of the next frame proceeds while the previous frame waits in the output register.
- Backpressure: with the output held and the buffer full, arg_rdy=0 until res_ack; transfer occurs on the res_ack edge.
- ARGN non-power-of-2: indices ARGN..2^IDXW-1 are always accepted and dropped.

Test Plan:
- ARGW=16, ARGN=2, res_rdy=1; send {0,0x1234} then {1,0xABCD} on consecutive cycles -> res_stb=1 one cycle after the 2nd accept, res_dat=0xABCD1234, res_stb low the following cycle.
- Out-of-order plus duplicate: send {1,0x0001}, then {1,0x0002} -> arg_rdy=0 for the duplicate, held until {0,0x0003} is accepted and the frame transfers; then the frame reads 0x00010003 and the held {1,0x0002} is accepted as the first word of the next frame.
- Backpressure: res_rdy=0, send two full frames F1=0x22221111 and F2=0x44443333 -> F1 held on res_dat, F2 fully buffered, arg_rdy=0 thereafter. Raise res_rdy for 1 cycle -> next cycle res_dat=F2, res_stb=1 (no bubble).
- ARGN=3, ARGW=8: send idx=3 data 0xFF -> accepted (arg_rdy=1), no effect. Then idx 2,0,1 with 0x03,0x01,0x02 -> res_dat=0x030201.
- Reset mid-frame: accept {0,0x5555}, assert rst 1 cycle, then send {1,0x6666} only -> no res_stb. Then send {0,0x7777} -> res_dat=0x66667777.
- Reset with frame pending: res_stb=1, res_rdy=0, assert rst -> res_stb=0 and res_dat=0 after the edge.

Source files
------------

// File: rtl/deserialize.sv
// deserialize: reassembles tagged {index,data} words into one ARGN-slot parallel frame.
// Ports: clk/rst (sync, active-high); arg_stb/arg_dat/arg_rdy tagged-word input handshake;
//        res_stb/res_dat/res_rdy registered frame output handshake (slot n at res_dat[ARGW*n +: ARGW]).
module deserialize #(
  parameter int ARGW = 16,
  parameter int ARGN = 2,
  localparam int IDXW = $clog2(ARGN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arg_stb,
  input  logic [IDXW+ARGW-1:0] arg_dat,
  output logic                 arg_rdy,
  output logic                 res_stb,
  output logic [ARGN*ARGW-1:0] res_dat,
  input  logic                 res_rdy
);
  logic [IDXW-1:0] idx;
  logic [ARGW-1:0] dat;
  logic [ARGW-1:0] buf_q [ARGN];
  logic [ARGW-1:0] buf_d [ARGN];
  logic [ARGN-1:0] msk_q, msk_d;
  logic [ARGN*ARGW-1:0] res_dat_q, res_dat_d, frame;
  logic res_stb_q, res_stb_d, full, hit, xfer;
  assign idx = arg_dat[IDXW+ARGW-1:ARGW];
  assign dat = arg_dat[ARGW-1:0];
  assign full = &msk_q;
  assign xfer = full & (~res_stb_q | res_rdy);
  // out-of-range tags never hit a slot, so they are always accepted (and dropped) unless full
  assign arg_rdy = ~full & ~hit;
  assign res_stb = res_stb_q;
  assign res_dat = res_dat_q;
  always_comb begin
    hit = 1'b0;
    frame = '0;
    for (int n = 0; n < ARGN; n++) begin
      hit = hit | (msk_q[n] & (idx == IDXW'(n)));
      frame[ARGW*n +: ARGW] = buf_q[n];
    end
  end
  // accept and transfer are mutually exclusive because arg_rdy is low while full
  always_comb begin
    buf_d = buf_q;
    msk_d = xfer ? '0 : msk_q;
    res_dat_d = xfer ? frame : res_dat_q;
    res_stb_d = xfer | (res_stb_q & ~res_rdy);
    for (int n = 0; n < ARGN; n++) begin
      if (arg_stb & arg_rdy & (idx == IDXW'(n))) begin
        buf_d[n] = dat;
        msk_d[n] = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      msk_q <= '0;
      res_stb_q <= 1'b0;
      res_dat_q <= '0;
    end else begin
      msk_q <= msk_d;
      res_stb_q <= res_stb_d;
      res_dat_q <= res_dat_d;
    end
  end
  always_ff @(posedge clk) buf_q <= buf_d;
endmodule

// File: tb/tb_deserialize.sv
// tb_deserialize: scoreboard bench for deserialize (ARGN=2/ARGW=16 and ARGN=3/ARGW=8 instances).
module tb_deserialize;
  logic clk = 0, rst = 1;
  logic a_stb = 0, a_rdy, ra_stb, ra_rdy = 1;
  logic [16:0] a_dat = '0;
  logic [31:0] ra_dat;
  logic b_stb = 0, b_rdy, rb_stb, rb_rdy = 1;
  logic [9:0] b_dat = '0;
  logic [23:0] rb_dat;
  logic [31:0] qa[$];
  logic [23:0] qb[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  deserialize #(.ARGW(16), .ARGN(2)) dut_a (
    .clk(clk), .rst(rst), .arg_stb(a_stb), .arg_dat(a_dat), .arg_rdy(a_rdy),
    .res_stb(ra_stb), .res_dat(ra_dat), .res_rdy(ra_rdy));

  deserialize #(.ARGW(8), .ARGN(3)) dut_b (
    .clk(clk), .rst(rst), .arg_stb(b_stb), .arg_dat(b_dat), .arg_rdy(b_rdy),
    .res_stb(rb_stb), .res_dat(rb_dat), .res_rdy(rb_rdy));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ra_stb && ra_rdy) begin
      if (qa.size() == 0) chk("a_unexpected_frame", 64'(ra_dat), 64'hDEAD_0000_0000);
      else chk("a_frame", 64'(ra_dat), 64'(qa.pop_front()));
    end
    if (!rst && rb_stb && rb_rdy) begin
      if (qb.size() == 0) chk("b_unexpected_frame", 64'(rb_dat), 64'hDEAD_0000_0000);
      else chk("b_frame", 64'(rb_dat), 64'(qb.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_a(input logic idx, input logic [15:0] d);
    int n = 0;
    a_stb = 1; a_dat = {idx, d};
    @(negedge clk);
    while (!a_rdy && n < 50) begin @(negedge clk); n++; end
    if (!a_rdy) chk("a_accept_timeout", 64'(a_rdy), 64'd1);
    tick();
    a_stb = 0;
  endtask

  task automatic send_b(input logic [1:0] idx, input logic [7:0] d);
    int n = 0;
    b_stb = 1; b_dat = {idx, d};
    @(negedge clk);
    while (!b_rdy && n < 50) begin @(negedge clk); n++; end
    if (!b_rdy) chk("b_accept_timeout", 64'(b_rdy), 64'd1);
    tick();
    b_stb = 0;
  endtask

  initial begin
    repeat (2) tick();
    chk("reset_ra_stb", 64'(ra_stb), 0);
    chk("reset_ra_dat", 64'(ra_dat), 0);
    chk("reset_rb_stb", 64'(rb_stb), 0);
    chk("reset_a_rdy", 64'(a_rdy), 1);
    rst = 0;
    tick();
    // basic in-order frame
    qa.push_back(32'hABCD1234);
    send_a(0, 16'h1234);
    send_a(1, 16'hABCD);
    chk("basic_stb_low_before_xfer", 64'(ra_stb), 0);
    tick();
    chk("basic_stb", 64'(ra_stb), 1);
    chk("basic_dat", 64'(ra_dat), 64'hABCD1234);
    tick();
    chk("basic_stb_drop", 64'(ra_stb), 0);
    // out-of-order with duplicate tag
    qa.push_back(32'h00010003);
    qa.push_back(32'h00020004);
    send_a(1, 16'h0001);
    a_stb = 1; a_dat = {1'b1, 16'h0002};
    repeat (3) begin
      @(negedge clk);
      chk("dup_stalled", 64'(a_rdy), 0);
    end
    tick();
    a_stb = 0;
    send_a(0, 16'h0003);
    send_a(1, 16'h0002);
    send_a(0, 16'h0004);
    repeat (3) tick();
    // backpressure with both frames buffered
    ra_rdy = 0;
    qa.push_back(32'h22221111);
    qa.push_back(32'h44443333);
    send_a(0, 16'h1111);
    send_a(1, 16'h2222);
    send_a(0, 16'h3333);
    send_a(1, 16'h4444);
    repeat (3) tick();
    @(negedge clk);
    chk("bp_a_rdy_low", 64'(a_rdy), 0);
    chk("bp_hold_stb", 64'(ra_stb), 1);
    chk("bp_hold_f1", 64'(ra_dat), 64'h22221111);
    tick();
    ra_rdy = 1;
    tick();
    ra_rdy = 0;
    chk("bp_no_bubble_stb", 64'(ra_stb), 1);
    chk("bp_f2", 64'(ra_dat), 64'h44443333);
    chk("bp_a_rdy_free", 64'(a_rdy), 1);
    tick();
    ra_rdy = 1;
    repeat (2) tick();
    chk("bp_drained_stb", 64'(ra_stb), 0);
    // ARGN=3: out-of-range tag dropped, then reordered frame
    b_stb = 1; b_dat = {2'd3, 8'hFF};
    @(negedge clk);
    chk("b_oor_rdy", 64'(b_rdy), 1);
    tick();
    b_stb = 0;
    repeat (2) tick();
    chk("b_oor_no_frame", 64'(rb_stb), 0);
    qb.push_back(24'h030201);
    send_b(2, 8'h03);
    send_b(0, 8'h01);
    send_b(1, 8'h02);
    repeat (3) tick();
    // reset mid-frame discards the partial frame
    send_a(0, 16'h5555);
    rst = 1;
    tick();
    rst = 0;
    send_a(1, 16'h6666);
    repeat (3) tick();
    chk("rst_mid_no_frame", 64'(ra_stb), 0);
    qa.push_back(32'h66667777);
    send_a(0, 16'h7777);
    repeat (3) tick();
    // reset with a frame pending on the output
    ra_rdy = 0;
    send_a(0, 16'h0001);
    send_a(1, 16'h0002);
    repeat (2) tick();
    chk("pend_stb", 64'(ra_stb), 1);
    chk("pend_dat", 64'(ra_dat), 64'h00020001);
    rst = 1;
    tick();
    chk("pend_rst_stb", 64'(ra_stb), 0);
    chk("pend_rst_dat", 64'(ra_dat), 0);
    rst = 0;
    ra_rdy = 1;
    tick();
    chk("pend_rst_a_rdy", 64'(a_rdy), 1);
    repeat (3) tick();
    chk("qa_drained", 64'(qa.size()), 0);
    chk("qb_drained", 64'(qb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
